// File: rtl/reg_file_ctrl_if.sv
// -----------------------------------------------------------------------------
// reg_file_ctrl_if
//   Instruction handshake and completion status between a requester and the
//   register-file sequencer.
//   instr_valid / instr  : requester -> controller (instr = {op, rd, rs, imm})
//   instr_ready          : controller -> requester
//   done/result/carry/zero : controller -> requester, status of the last write
// -----------------------------------------------------------------------------
interface reg_file_ctrl_if;
   logic       instr_valid;
   logic       instr_ready;
   logic [9:0] instr;
   logic       done;
   logic [3:0] result;
   logic       carry;
   logic       zero;

   modport master (
      output instr_valid, instr,
      input  instr_ready, done, result, carry, zero
   );

   modport slave (
      input  instr_valid, instr,
      output instr_ready, done, result, carry, zero
   );
endinterface

// File: rtl/reg_file_ctrl.sv
// -----------------------------------------------------------------------------
// reg_file_ctrl
//   Sequencer for a 4x4-bit register file that has no write enable. Executes
//   LDI/MOV/ADD/SUB one instruction at a time (IDLE -> READ -> WRITE) and can
//   zero R0..R3 after reset. Every cycle that is not a real write is turned
//   into a self-refresh: the register on SEL_W gets its own value back.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     bus (slave)     instruction handshake + done/result/carry/zero status
//     rf_sel_a/b      read selects to the file
//     rf_sel_w        write select to the file
//     rf_data_in      write data to the file
//     rf_out_a/b      combinational read data from the file
// -----------------------------------------------------------------------------
module reg_file_ctrl #(
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   reg_file_ctrl_if.slave  bus,
   output logic [1:0]      rf_sel_a,
   output logic [1:0]      rf_sel_b,
   output logic [1:0]      rf_sel_w,
   output logic [3:0]      rf_data_in,
   input  logic [3:0]      rf_out_a,
   input  logic [3:0]      rf_out_b
);

   typedef enum logic [1:0] {S_CLR, S_IDLE, S_READ, S_WRITE} state_e;

   state_e     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [9:0] instr_q;
   logic [3:0] res_q;
   logic       cy_q;
   logic [3:0] result_q;
   logic       carry_q, zero_q, done_q;

   logic [1:0] op, rd, rs;
   logic [3:0] imm;
   logic [4:0] alu;

   assign op  = instr_q[9:8];
   assign rd  = instr_q[7:6];
   assign rs  = instr_q[5:4];
   assign imm = instr_q[3:0];

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR_ON_RESET ? S_CLR : S_IDLE;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_CLR: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = S_IDLE;
         end
         S_IDLE:  if (bus.instr_valid) state_d = S_READ;
         S_READ:  state_d = S_WRITE;
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   // own_wr marks the cycles that really write (CLR, WRITE); all others refresh.
   logic       own_wr;
   logic [1:0] wsel;
   logic [3:0] wdat;
   logic       rdy;

   always_comb begin
      rdy      = 1'b0;
      rf_sel_a = 2'd0;
      rf_sel_b = 2'd0;
      own_wr   = 1'b0;
      wsel     = 2'd0;
      wdat     = 4'd0;
      if (!rst) begin
         case (state_q)
            S_CLR: begin
               own_wr = 1'b1;
               wsel   = cnt_q;
            end
            S_IDLE: rdy = 1'b1;
            S_READ: begin
               rf_sel_a = rd;
               rf_sel_b = rs;
            end
            S_WRITE: begin
               own_wr = 1'b1;
               wsel   = rd;
               wdat   = res_q;
            end
            default: ;
         endcase
      end
   end

   assign rf_sel_w        = own_wr ? wsel : rf_sel_b;
   assign rf_data_in      = own_wr ? wdat : rf_out_b;
   assign bus.instr_ready = rdy;
   assign bus.done        = done_q;
   assign bus.result      = result_q;
   assign bus.carry       = carry_q;
   assign bus.zero        = zero_q;

   // ---------------- datapath ----------------
   // bit 4 is the ADD carry-out, or the SUB borrow (opA < opB).
   always_comb begin
      case (op)
         2'b00:   alu = {1'b0, imm};
         2'b01:   alu = {1'b0, rf_out_b};
         2'b10:   alu = {1'b0, rf_out_a} + {1'b0, rf_out_b};
         default: alu = {1'b0, rf_out_a} - {1'b0, rf_out_b};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q  <= 10'd0;
         res_q    <= 4'd0;
         cy_q     <= 1'b0;
         result_q <= 4'd0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state_q == S_WRITE);
         if (state_q == S_IDLE && bus.instr_valid) instr_q <= bus.instr;
         if (state_q == S_READ) {cy_q, res_q} <= alu;
         if (state_q == S_WRITE) begin
            result_q <= res_q;
            zero_q   <= (res_q == 4'd0);
            if (op[1]) carry_q <= cy_q;   // LDI/MOV leave carry alone
         end
      end
   end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_file_ctrl
//   Drives reg_file_ctrl against a behavioural 4x4 register file and checks it
//   with a reference model of the instruction set kept as plain arrays.
// -----------------------------------------------------------------------------
module tb_reg_file_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] rf_sel_a, rf_sel_b, rf_sel_w;
   logic [3:0] rf_data_in, rf_out_a, rf_out_b;

   reg_file_ctrl_if ifc ();

   reg_file_ctrl #(.CLEAR_ON_RESET(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (ifc.slave),
      .rf_sel_a   (rf_sel_a),
      .rf_sel_b   (rf_sel_b),
      .rf_sel_w   (rf_sel_w),
      .rf_data_in (rf_data_in),
      .rf_out_a   (rf_out_a),
      .rf_out_b   (rf_out_b)
   );

   always #5 clk = ~clk;

   // Register file: combinational reads, unconditional write every edge.
   logic [3:0] rf [4];
   always @(posedge clk) rf[rf_sel_w] <= rf_data_in;
   assign rf_out_a = rf[rf_sel_a];
   assign rf_out_b = rf[rf_sel_b];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model
   logic [3:0] m [4];
   logic [3:0] exp_res;
   logic       exp_c, exp_z;
   int         last_hs;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic check_rf();
      for (int i = 0; i < 4; i++) chk($sformatf("rf[%0d]", i), rf[i], m[i]);
   endtask

   // Assert reset, then check the 4-cycle clear and the zeroed file.
   task automatic reset_seq();
      rst = 1'b1;
      ifc.instr_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", ifc.instr_ready, 0);
      chk("rst_done", ifc.done, 0);
      chk("rst_result", ifc.result, 0);
      chk("rst_carry", ifc.carry, 0);
      chk("rst_zero", ifc.zero, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("clr_ready", ifc.instr_ready, 0);
         @(negedge clk);
      end
      chk("clr_ready_up", ifc.instr_ready, 1);
      for (int i = 0; i < 4; i++) m[i] = 4'd0;
      exp_res = 4'd0; exp_c = 1'b0; exp_z = 1'b0;
      check_rf();
      last_hs = -100;
   endtask

   // Called at a negedge. Presents one instruction, waits for the handshake,
   // checks READ/WRITE cycles and the completion cycle. With hold=1 valid stays
   // high through the busy cycles; the next call replaces instr in time.
   task automatic exec(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [3:0] imm, input bit hold, input bit chk_gap);
      int n;
      int a, b, r;
      ifc.instr       = {op, rd, rs, imm};
      ifc.instr_valid = 1'b1;
      n = 0;
      while (!ifc.instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ifc.instr_ready) begin
         chk("handshake_timeout", 0, 1);
         ifc.instr_valid = 1'b0;
         return;
      end
      if (chk_gap) chk("accept_gap", cyc - last_hs, 3);
      last_hs = cyc;
      a = m[rd]; b = m[rs];
      case (op)
         2'b00: r = imm;
         2'b01: r = b;
         2'b10: begin r = (a + b) % 16; exp_c = (a + b) > 15; end
         default: begin r = (a - b + 16) % 16; exp_c = a < b; end
      endcase
      m[rd]   = r[3:0];
      exp_res = r[3:0];
      exp_z   = (r == 0);
      @(negedge clk);                       // READ
      chk("read_ready", ifc.instr_ready, 0);
      chk("read_done", ifc.done, 0);
      if (!hold) ifc.instr_valid = 1'b0;
      @(negedge clk);                       // WRITE
      chk("write_ready", ifc.instr_ready, 0);
      chk("write_done", ifc.done, 0);
      @(negedge clk);                       // completion
      chk("done", ifc.done, 1);
      chk("ready_back", ifc.instr_ready, 1);
      chk("result", ifc.result, exp_res);
      chk("carry", ifc.carry, exp_c);
      chk("zero", ifc.zero, exp_z);
      chk("rf_rd", rf[rd], m[rd]);
   endtask

   initial begin
      rst = 1'b1;
      ifc.instr_valid = 1'b0;
      ifc.instr = 10'd0;
      exp_c = 1'b0; exp_z = 1'b0; exp_res = 4'd0;
      last_hs = -100;
      for (int i = 0; i < 4; i++) m[i] = 4'd0;
      @(negedge clk);
      reset_seq();

      // load, copy
      exec(2'b00, 2'd2, 2'd0, 4'd9, 0, 0);
      exec(2'b01, 2'd3, 2'd2, 4'd0, 0, 0);
      check_rf();

      // carry / zero corners
      exec(2'b00, 2'd1, 2'd0, 4'hF, 0, 0);
      exec(2'b00, 2'd2, 2'd0, 4'h1, 0, 0);
      exec(2'b10, 2'd1, 2'd2, 4'd0, 0, 0);
      exec(2'b11, 2'd2, 2'd1, 4'd0, 0, 0);
      exec(2'b11, 2'd1, 2'd2, 4'd0, 0, 0);  // 0 - 1 borrows
      exec(2'b10, 2'd2, 2'd2, 4'd0, 0, 0);  // rd == rs doubles

      // refresh must never corrupt idle contents
      for (int i = 0; i < 4; i++) exec(2'b00, i[1:0], 2'd0, 4'(i + 1), 0, 0);
      repeat (20) @(negedge clk);
      chk("idle_done", ifc.done, 0);
      check_rf();

      // back-to-back stream with valid held through busy cycles
      for (int i = 0; i < 8; i++)
         exec(2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)),
              4'($urandom_range(15)), i != 7, i != 0);
      check_rf();

      // random stream with idle gaps
      for (int i = 0; i < 30; i++) begin
         exec(2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)),
              4'($urandom_range(15)), 0, 0);
         repeat ($urandom_range(2)) @(negedge clk);
      end
      check_rf();

      // reset during WRITE aborts the instruction
      exec(2'b00, 2'd0, 2'd0, 4'd5, 0, 0);
      ifc.instr = {2'b00, 2'd0, 2'd0, 4'd7};
      ifc.instr_valid = 1'b1;
      @(negedge clk);                       // READ
      ifc.instr_valid = 1'b0;
      @(negedge clk);                       // WRITE
      rst = 1'b1;
      @(negedge clk);
      chk("abort_done", ifc.done, 0);
      chk("abort_ready", ifc.instr_ready, 0);
      chk("abort_result", ifc.result, 0);
      chk("abort_carry", ifc.carry, 0);
      chk("abort_zero", ifc.zero, 0);
      chk("abort_r0_kept", rf[0], 4'd5);
      @(negedge clk);
      chk("abort_r0_kept2", rf[0], 4'd5);
      chk("abort_no_done", ifc.done, 0);
      reset_seq();
      exec(2'b00, 2'd3, 2'd0, 4'd6, 0, 0);
      check_rf();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
